seq_alu_md: RTL and testbench
=============================

SEQ_ALU_MD -- requirements
Module: seq_alu_md

Interface
REQ-001 Parameter XLEN, default 32, sets operand and result width; legal values are 8, 16, 32 and 64.
REQ-002 Parameter SHW, default $clog2(XLEN), sets the shift-amount width; it SHALL NOT be overridden.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand/op bundle is valid.
REQ-006 in_ready  output  1  block accepts a bundle this cycle.
REQ-007 op  input  5  operation select; encodings are defined in alu_pkg.
REQ-008 a, b  input  XLEN  operands.
REQ-009 out_valid  output  1  result is valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  XLEN  registered result.
REQ-012 zero  output  1  registered; high when result == 0.
REQ-013 illegal  output  1  registered; high when op is unencoded.

Function
REQ-014 Base ops SHALL be: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
REQ-015 M ops SHALL be: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, with RISC-V M semantics at width XLEN.
REQ-016 Shifts SHALL use only b[SHW-1:0]; SRA sign-fills from a[XLEN-1].
REQ-017 SLT compares a and b as signed; SLTU compares them as unsigned; the result is 1 or 0, zero-extended to XLEN.
REQ-018 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-019 A bundle is accepted when in_valid && in_ready; in_ready SHALL be high only in IDLE.
REQ-020 A base op or an illegal op SHALL move IDLE->DONE, so out_valid rises the cycle after acceptance (latency 1).
REQ-021 An M op SHALL move IDLE->BUSY and iterate one bit per cycle for exactly XLEN cycles, then go to DONE; out_valid rises XLEN+1 cycles after acceptance.
REQ-022 Multiply SHALL be shift-add on magnitudes with sign correction; divide SHALL be restoring division on magnitudes with sign correction.
REQ-023 DONE SHALL hold result, zero and illegal stable until out_valid && out_ready, then go to IDLE.
REQ-024 Back-to-back acceptance is not allowed: the earliest next acceptance is the cycle after the handshake.
REQ-025 Divide by zero SHALL give DIV/DIVU quotient all-ones and REM/REMU remainder = a; it SHALL complete in the same XLEN+1 cycles.
REQ-026 Signed overflow (a = most-negative, b = -1) SHALL give DIV = a and REM = 0.
REQ-027 An illegal op SHALL give result 0, zero = 1 and illegal = 1.
REQ-028 in_valid during BUSY or DONE SHALL be ignored and SHALL NOT corrupt state.
REQ-029 Operands SHALL be captured at acceptance; changes to a, b or op afterwards have no effect.

Reset
REQ-030 On rst_n low, the block SHALL go to IDLE immediately and set in_ready=0 while reset is asserted, out_valid=0, result=0, zero=1, illegal=0, and clear iteration counters.
REQ-031 Reset mid-BUSY or mid-DONE SHALL abandon the operation; no result is emitted after release.
REQ-032 in_ready SHALL rise the first clock after rst_n deasserts.

Structure
REQ-033 Package alu_pkg SHALL hold the op enum (5-bit), the state enum, and an is_md() helper classification.
REQ-034 Sub-module md_iter SHALL hold the iterative multiply/divide datapath and counter, with a start/done interface; seq_alu_md holds the FSM, the base-op logic and the output registers.

Verification
REQ-035 XLEN=32, ADD a=0xFFFFFFFF, b=1 -> out_valid 1 cycle after acceptance, result=0, zero=1.
REQ-036 XLEN=32, MULH a=0x80000000, b=0x80000000 -> result=0x40000000 exactly 33 cycles after acceptance; in_ready low throughout.
REQ-037 XLEN=32, DIV a=7, b=0 -> result=0xFFFFFFFF; REM a=7, b=0 -> result=7; DIV a=0x80000000, b=0xFFFFFFFF -> result=0x80000000.
REQ-038 XLEN=8, SRA a=0x90, b=0x0C (shift amount 4) -> result=0xF9; DIVU a=200, b=7 -> result=28 after 9 cycles.
REQ-039 Hold out_ready low for 5 cycles in DONE -> result stable, in_ready=0; assert rst_n low mid-BUSY -> out_valid never rises and in_ready rises the cycle after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op encodings, FSM states and op classification for the sequential ALU.
package alu_pkg;

  typedef enum logic [4:0] {
    OpAdd    = 5'd0,
    OpSub    = 5'd1,
    OpSll    = 5'd2,
    OpSlt    = 5'd3,
    OpSltu   = 5'd4,
    OpXor    = 5'd5,
    OpSrl    = 5'd6,
    OpSra    = 5'd7,
    OpOr     = 5'd8,
    OpAnd    = 5'd9,
    OpMul    = 5'd16,
    OpMulh   = 5'd17,
    OpMulhsu = 5'd18,
    OpMulhu  = 5'd19,
    OpDiv    = 5'd20,
    OpDivu   = 5'd21,
    OpRem    = 5'd22,
    OpRemu   = 5'd23
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  localparam logic [4:0] NumBaseOps = 5'd10;

  // Multiply/divide ops occupy codes 16..23.
  function automatic logic is_md(logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

  function automatic logic is_base(logic [4:0] op);
    return op < NumBaseOps;
  endfunction

endpackage

// File: rtl/md_iter.sv
// Iterative multiply/divide: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle for XLEN cycles, with sign correction on the way out.
module md_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [SHW-1:0] LastCnt = SHW'(XLEN - 1);

  logic              busy_q;
  logic [SHW-1:0]    cnt_q;
  logic              div_q, neg_q, sel_q;
  logic [XLEN-1:0]   hi_q, lo_q, dv_q;
  logic [XLEN-1:0]   hi_d, lo_d;

  logic              a_sgn, b_sgn, sel_op, is_div, sa, sb, neg_op;
  logic [XLEN-1:0]   ma, mb;
  logic [XLEN:0]     sum, shifted;
  logic              ge;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   qr;

  // sel_op picks the high product half for MULH*, or the remainder for REM*.
  always_comb begin
    a_sgn  = 1'b0;
    b_sgn  = 1'b0;
    sel_op = 1'b0;
    case (op)
      OpMulh:   begin a_sgn = 1'b1; b_sgn = 1'b1; sel_op = 1'b1; end
      OpMulhsu: begin a_sgn = 1'b1; sel_op = 1'b1; end
      OpMulhu:  sel_op = 1'b1;
      OpDiv:    begin a_sgn = 1'b1; b_sgn = 1'b1; end
      OpRem:    begin a_sgn = 1'b1; b_sgn = 1'b1; sel_op = 1'b1; end
      OpRemu:   sel_op = 1'b1;
      default:  ;
    endcase
  end

  assign is_div = op[2];
  assign sa     = a_sgn & a[XLEN-1];
  assign sb     = b_sgn & b[XLEN-1];
  assign ma     = sa ? -a : a;
  assign mb     = sb ? -b : b;
  // Remainder follows the dividend; a zero divisor keeps the quotient all-ones.
  assign neg_op = (is_div && sel_op) ? sa : ((sa ^ sb) && !(is_div && (b == '0)));

  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dv_q} : '0);
    shifted = {hi_q, lo_q[XLEN-1]};
    ge      = shifted >= {1'b0, dv_q};
    if (div_q) begin
      hi_d = ge ? (shifted[XLEN-1:0] - dv_q) : shifted[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], ge};
    end else begin
      hi_d = sum[XLEN:1];
      lo_d = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Result reflects the step being taken this cycle, so it is final when done is high.
  always_comb begin
    prod = neg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
    qr   = sel_q ? hi_d : lo_d;
    if (neg_q) begin
      qr = -qr;
    end
    result = div_q ? qr : (sel_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0]);
  end

  assign done = busy_q && (cnt_q == LastCnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      sel_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      dv_q   <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      div_q  <= is_div;
      neg_q  <= neg_op;
      sel_q  <= sel_op;
      hi_q   <= '0;
      lo_q   <= ma;
      dv_q   <= mb;
    end else if (busy_q) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + SHW'(1);
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_alu_md.sv
// Sequential RV-style ALU with M extension: single-cycle base ops, iterative
// multiply/divide, one transaction in flight with a valid/ready handshake on each side.
module seq_alu_md
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  state_e          state_q, state_d;
  logic            armed_q;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;

  logic            accept, op_md, op_legal, md_start, md_done;
  logic [XLEN-1:0] base_res, md_res;
  logic [SHW-1:0]  shamt;

  // armed_q keeps in_ready low through reset and until the first clock after release.
  assign in_ready  = (state_q == StIdle) && armed_q;
  assign accept    = in_valid && in_ready;
  assign op_md     = is_md(op);
  assign op_legal  = op_md || is_base(op);
  assign md_start  = accept && op_md;
  assign shamt     = b[SHW-1:0];

  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

  always_comb begin
    base_res = '0;
    case (op)
      OpAdd:   base_res = a + b;
      OpSub:   base_res = a - b;
      OpSll:   base_res = a << shamt;
      OpSlt:   base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OpSltu:  base_res = {{(XLEN-1){1'b0}}, (a < b)};
      OpXor:   base_res = a ^ b;
      OpSrl:   base_res = a >> shamt;
      OpSra:   base_res = $unsigned($signed(a) >>> shamt);
      OpOr:    base_res = a | b;
      OpAnd:   base_res = a & b;
      default: base_res = '0;
    endcase
  end

  md_iter #(
    .XLEN (XLEN),
    .SHW  (SHW)
  ) u_md_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .op     (op),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .result (md_res)
  );

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (op_md) begin
            state_d = StBusy;
          end else begin
            state_d   = StDone;
            result_d  = base_res;
            zero_d    = (base_res == '0);
            illegal_d = !op_legal;
          end
        end
      end
      StBusy: begin
        if (md_done) begin
          state_d   = StDone;
          result_d  = md_res;
          zero_d    = (md_res == '0);
          illegal_d = 1'b0;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      armed_q   <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= 1'b1;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_seq_alu_md.sv
// Scoreboard bench for seq_alu_md at XLEN=32 and XLEN=8 against an arithmetic reference model.
module tb_seq_alu_md;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel8 = 1'b0;
  logic        drv_valid = 1'b0;
  logic [4:0]  drv_op = '0;
  logic [63:0] drv_a = '0, drv_b = '0;
  logic        out_ready = 1'b1;
  logic        rdy_rand = 1'b0;

  logic        iv32, ir32, ov32, z32, il32;
  logic [31:0] r32;
  logic        iv8, ir8, ov8, z8, il8;
  logic [7:0]  r8;

  assign iv32 = drv_valid && !sel8;
  assign iv8  = drv_valid && sel8;

  seq_alu_md #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .op(drv_op),
    .a(drv_a[31:0]), .b(drv_b[31:0]), .out_valid(ov32), .out_ready(out_ready),
    .result(r32), .zero(z32), .illegal(il32)
  );

  seq_alu_md #(.XLEN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op(drv_op),
    .a(drv_a[7:0]), .b(drv_b[7:0]), .out_valid(ov8), .out_ready(out_ready),
    .result(r8), .zero(z8), .illegal(il8)
  );

  logic        cv, cr, cz, cil;
  logic [63:0] cres;
  assign cv   = sel8 ? ov8 : ov32;
  assign cr   = sel8 ? ir8 : ir32;
  assign cz   = sel8 ? z8 : z32;
  assign cil  = sel8 ? il8 : il32;
  assign cres = sel8 ? {56'b0, r8} : {32'b0, r32};

  typedef struct {
    logic [63:0] res;
    logic        ill;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference model: plain signed/unsigned arithmetic at width w.
  function automatic logic [63:0] model(input logic [4:0] o, input logic [63:0] x,
                                        input logic [63:0] y, input int w, output logic ill);
    logic [63:0] mask, ux, uy;
    longint      sx, sy, r;
    int          sh;
    mask = (64'd1 << w) - 64'd1;
    ux   = x & mask;
    uy   = y & mask;
    sx   = $signed(x << (64 - w)) >>> (64 - w);
    sy   = $signed(y << (64 - w)) >>> (64 - w);
    sh   = int'(uy % 64'(w));
    ill  = 1'b0;
    case (o)
      OpAdd:    r = longint'(ux + uy);
      OpSub:    r = longint'(ux - uy);
      OpSll:    r = longint'(ux << sh);
      OpSlt:    r = (sx < sy) ? 64'sd1 : 64'sd0;
      OpSltu:   r = (ux < uy) ? 64'sd1 : 64'sd0;
      OpXor:    r = longint'(ux ^ uy);
      OpSrl:    r = longint'(ux >> sh);
      OpSra:    r = sx >>> sh;
      OpOr:     r = longint'(ux | uy);
      OpAnd:    r = longint'(ux & uy);
      OpMul:    r = sx * sy;
      OpMulh:   r = (sx * sy) >>> w;
      OpMulhsu: r = (sx * longint'(uy)) >>> w;
      OpMulhu:  r = longint'((ux * uy) >> w);
      OpDiv:    r = (uy == 64'd0) ? -64'sd1 : sx / sy;
      OpDivu:   r = (uy == 64'd0) ? -64'sd1 : longint'(ux / uy);
      OpRem:    r = (uy == 64'd0) ? sx : sx % sy;
      OpRemu:   r = (uy == 64'd0) ? longint'(ux) : longint'(ux % uy);
      default: begin
        r   = 64'sd0;
        ill = 1'b1;
      end
    endcase
    return 64'(r) & mask;
  endfunction

  function automatic logic [63:0] pick(input int w);
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'd1;
      2:       return 64'hFFFF_FFFF_FFFF_FFFF;
      3:       return 64'd1 << (w - 1);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Waits for in_ready with junk on the bus (valid held high), then issues the real bundle.
  task automatic send(input logic [4:0] o, input logic [63:0] x, input logic [63:0] y,
                      input bit use_exp, input logic [63:0] expv);
    int          w = sel8 ? 8 : 32;
    int          t = 0;
    exp_t        e;
    logic        ill;
    logic [63:0] m;
    @(negedge clk);
    drv_valid = 1'b1;
    while (!cr && t < 300) begin
      drv_op = 5'($urandom);
      drv_a  = {$urandom, $urandom};
      drv_b  = {$urandom, $urandom};
      @(negedge clk);
      t++;
    end
    if (!cr) begin
      check("accept_timeout", 64'(cr), 64'd1);
      drv_valid = 1'b0;
      return;
    end
    drv_op = o;
    drv_a  = x;
    drv_b  = y;
    m      = model(o, x, y, w, ill);
    e.res  = use_exp ? expv : m;
    e.ill  = ill;
    e.acc  = cyc;
    e.lat  = (o >= 5'd16 && o <= 5'd23) ? w + 1 : 1;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
    drv_op    = 5'($urandom);
    drv_a     = {$urandom, $urandom};
    drv_b     = {$urandom, $urandom};
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() > 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (sbq.size() > 0) check("drain_timeout", 64'(sbq.size()), 64'd0);
    @(negedge clk);
  endtask

  // Monitor: compares on the first out_valid cycle, then checks hold until the handshake.
  logic        prev_v = 1'b0;
  logic [63:0] hold_res;
  logic        hold_z, hold_il;
  initial forever begin
    @(negedge clk);
    if (rst_n && cv) begin
      if (!prev_v) begin
        if (sbq.size() == 0) begin
          check("unexpected_out_valid", 64'(cv), 64'd0);
        end else begin
          check("latency", 64'(cyc - sbq[0].acc), 64'(sbq[0].lat));
          check("result", cres, sbq[0].res);
          check("zero", 64'(cz), 64'(sbq[0].res == 64'd0));
          check("illegal", 64'(cil), 64'(sbq[0].ill));
        end
      end else begin
        check("hold_result", cres, hold_res);
        check("hold_flags", 64'({cz, cil}), 64'({hold_z, hold_il}));
      end
      check("in_ready_in_done", 64'(cr), 64'd0);
      hold_res = cres;
      hold_z   = cz;
      hold_il  = cil;
      if (out_ready && sbq.size() > 0) void'(sbq.pop_front());
    end
    prev_v = cv;
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int seen;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(ir32), 64'd0);
    check("rst_out_valid", 64'(ov32), 64'd0);
    check("rst_result", 64'(r32), 64'd0);
    check("rst_zero", 64'(z32), 64'd1);
    check("rst_illegal", 64'(il32), 64'd0);
    check("rst_in_ready8", 64'(ir8), 64'd0);
    rst_n = 1'b1;
    #1;
    check("in_ready_before_first_clk", 64'(ir32), 64'd0);
    @(posedge clk);
    #1;
    check("in_ready_after_release", 64'(ir32), 64'd1);

    send(OpAdd, 64'hFFFF_FFFF, 64'd1, 1'b1, 64'd0);
    send(OpMulh, 64'h8000_0000, 64'h8000_0000, 1'b1, 64'h4000_0000);
    repeat (32) begin
      @(negedge clk);
      check("in_ready_busy", 64'(cr), 64'd0);
    end
    send(OpDiv, 64'd7, 64'd0, 1'b1, 64'hFFFF_FFFF);
    send(OpRem, 64'd7, 64'd0, 1'b1, 64'd7);
    send(OpDiv, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 64'h8000_0000);
    send(OpRem, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 64'd0);
    send(5'd12, 64'd5, 64'd5, 1'b1, 64'd0);
    drain();

    // Consumer stall in DONE
    out_ready = 1'b0;
    send(OpSub, 64'd10, 64'd3, 1'b1, 64'd7);
    t = 0;
    while (!cv && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("stall_valid", 64'(cv), 64'd1);
    repeat (5) @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    rdy_rand = 1'b1;
    repeat (50) send(5'($urandom_range(0, 27)), pick(32), pick(32), 1'b0, 64'd0);
    drain();
    rdy_rand = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;

    // Reset mid-BUSY abandons the multiply
    send(OpMul, 64'd1234, 64'd5678, 1'b0, 64'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    sbq.delete();
    repeat (2) @(negedge clk);
    check("rst_mid_busy_out_valid", 64'(ov32), 64'd0);
    rst_n = 1'b1;
    #1;
    check("in_ready_before_clk_rel2", 64'(ir32), 64'd0);
    @(posedge clk);
    #1;
    check("in_ready_after_rel2", 64'(ir32), 64'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ov32) seen++;
    end
    check("no_result_after_reset", 64'(seen), 64'd0);

    sel8 = 1'b1;
    send(OpSra, 64'h90, 64'h0C, 1'b1, 64'hF9);
    send(OpDivu, 64'd200, 64'd7, 1'b1, 64'd28);
    send(OpDiv, 64'h80, 64'hFF, 1'b1, 64'h80);
    rdy_rand = 1'b1;
    repeat (40) send(5'($urandom_range(0, 27)), pick(8), pick(8), 1'b0, 64'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
